// File: rtl/wb_uart_tx_pkg.sv
// Shared types and status-word layout for the Wishbone UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Bit positions inside the status word returned on a read.
  localparam int unsigned ST_FULL      = 0;
  localparam int unsigned ST_EMPTY     = 1;
  localparam int unsigned ST_BUSY      = 2;
  localparam int unsigned ST_PARITY    = 3;
  localparam int unsigned ST_LEVEL_LSB = 8;

endpackage

// File: rtl/wb_uart_tx_fifo.sv
// Synchronous FIFO with occupancy count; shared between the TX path and a future RX path.
// Push is ignored when full and pop is ignored when empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned LW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push_ok, pop_ok;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Pointer and level update; pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents need no reset since level gates every read.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/wb_uart_tx.sv
// Wishbone B4 classic slave feeding a TX FIFO and an 8N1 UART serializer.
// Optional feature: define UART_TX_PARITY_EN to append an even-parity bit to each frame.
module wb_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        tx_o
);

  localparam int unsigned LvlW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);

  logic            fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [LvlW-1:0] fifo_level;
  logic [7:0]      fifo_rdata;

  logic            ack_q, ack_d;
  logic [31:0]     dat_q, dat_d;
  logic [31:0]     status;
  logic            req, rd_req;

  tx_state_t       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            cnt_last;

  // Only one register lives here, so address and upper data bits carry no meaning.
  logic unused_bus;
  assign unused_bus = ^{wb_adr_i, wb_dat_i[31:8]};

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (fifo_push),
    .pop_i  (fifo_pop),
    .wdata_i(wb_dat_i[7:0]),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .level_o(fifo_level)
  );

  // Status word snapshot taken in the request cycle.
  always_comb begin
    status                        = '0;
    status[ST_FULL]               = fifo_full;
    status[ST_EMPTY]              = fifo_empty;
    status[ST_BUSY]               = (state_q != IDLE);
    status[ST_LEVEL_LSB +: 8]     = 8'(fifo_level);
`ifdef UART_TX_PARITY_EN
    status[ST_PARITY]             = 1'b1;
`endif
  end

  // Bus decode: ACK masks the request so each access gets exactly one pulse.
  // A full FIFO stalls writes; registered full means space freed by a pop is seen a cycle later.
  always_comb begin
    req       = wb_cyc_i & wb_stb_i & ~ack_q;
    rd_req    = req & ~wb_we_i;
    fifo_push = req & wb_we_i & ~fifo_full;
    ack_d     = fifo_push | rd_req;
    dat_d     = rd_req ? status : '0;
  end

  // Bus response registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= ack_d;
      dat_q <= dat_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;

  assign cnt_last = (cnt_q == CntW'(CLKS_PER_BIT - 1));

  // Serializer next state; tx_d follows the next state so tx_q lines up with state_q.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_last ? '0 : cnt_q + CntW'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          state_d  = START;
        end
      end
      START: begin
        if (cnt_last) begin
          state_d = DATA;
          bit_d   = 3'd0;
        end
      end
      DATA: begin
        if (cnt_last) begin
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (cnt_last) state_d = STOP;
      end
      STOP: begin
        if (cnt_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[bit_d];
      PARITY:  tx_d = ^shift_d;
      default: tx_d = 1'b1;
    endcase
  end

  // Serializer state; reset aborts any frame in flight and drives the line idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign tx_o = tx_q;

endmodule

// File: tb/tb_wb_uart_tx.sv
// Self-checking bench for wb_uart_tx: scoreboard of expected bytes, line-decoding monitor.
module tb_wb_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam bit          PAR_EN = 1'b1;
  localparam logic [31:0] PAR    = 32'h8;
`else
  localparam bit          PAR_EN = 1'b0;
  localparam logic [31:0] PAR    = 32'h0;
`endif
  localparam int FRAME_LEN = (PAR_EN ? 11 : 10) * CPB;

  logic        clk, rst_n;
  logic [31:0] adr, dat_w, dat_r;
  logic        we, cyc, stb, ack, tx;

  int total = 0;
  int bad = 0;
  int cyc_cnt = 0;
  int frames_done = 0;
  logic [7:0] exp_q[$];
  int frame_starts[$];

  wb_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .wb_adr_i(adr),
    .wb_dat_i(dat_w),
    .wb_we_i (we),
    .wb_cyc_i(cyc),
    .wb_stb_i(stb),
    .wb_dat_o(dat_r),
    .wb_ack_o(ack),
    .tx_o    (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc_cnt++;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference line level for cycle c of a frame carrying byte d.
  function automatic logic exp_level(input logic [7:0] d, input int c);
    int k;
    k = c / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (k == 9 && PAR_EN) return ^d;
    return 1'b1;
  endfunction

  // Monitor: captures each frame starting at a falling edge and checks it against the scoreboard.
  initial begin
    forever begin
      logic [7:0] e, dec;
      int mism;
      logic aborted, has;
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        frame_starts.push_back(cyc_cnt);
        aborted = 1'b0;
        mism    = 0;
        dec     = 8'h00;
        has     = (exp_q.size() > 0);
        e       = has ? exp_q[0] : 8'h00;
        for (int c = 0; c < FRAME_LEN; c++) begin
          if (c > 0) @(negedge clk);
          if (rst_n !== 1'b1) aborted = 1'b1;
          if (tx !== exp_level(e, c)) mism++;
          if ((c % CPB) == CPB / 2 && (c / CPB) >= 1 && (c / CPB) <= 8) dec[c/CPB-1] = tx;
        end
        if (!aborted) begin
          if (!has) begin
            check("unexpected_frame", {24'h0, dec}, 32'hFFFF_FFFF);
          end else begin
            void'(exp_q.pop_front());
            check("frame_byte", {24'h0, dec}, {24'h0, e});
            check("frame_wave", mism, 0);
          end
          frames_done++;
        end
      end
    end
  end

  task automatic wb_write(input logic [7:0] d, output int lat, output int acyc);
    @(posedge clk);
    #1;
    exp_q.push_back(d);
    dat_w      = $urandom();
    dat_w[7:0] = d;
    adr = 32'h0010_0000;
    we  = 1'b1;
    cyc = 1'b1;
    stb = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!ack && lat < 300);
    acyc = cyc_cnt;
    cyc = 1'b0;
    stb = 1'b0;
    we  = 1'b0;
    if (!ack) check("write_ack_timeout", {31'h0, ack}, 32'h1);
  endtask

  task automatic wb_read(output logic [31:0] d, output int lat);
    @(posedge clk);
    #1;
    we  = 1'b0;
    cyc = 1'b1;
    stb = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!ack && lat < 300);
    d   = dat_r;
    cyc = 1'b0;
    stb = 1'b0;
    check("read_latency", lat, 1);
    @(posedge clk);
    #1;
    check("read_ack_pulse", {31'h0, ack}, 32'h0);
    check("read_dat_idle", dat_r, 32'h0);
  endtask

  task automatic wait_frames(input int n);
    int t;
    t = 0;
    while (frames_done < n && t < 3000) begin
      @(posedge clk);
      t++;
    end
    check("frames_done", frames_done, n);
  endtask

  initial begin
    logic [31:0] st;
    int lat, acyc, n0, nacks, lows, t;
    int lats[6];
    int acycs[6];
    logic [7:0] b;

    rst_n = 1'b0;
    adr = '0; dat_w = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
    #23;
    check("reset_tx", {31'h0, tx}, 32'h1);
    check("reset_ack", {31'h0, ack}, 32'h0);
    check("reset_dat", dat_r, 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Idle status.
    wb_read(st, lat);
    check("status_reset", st, 32'h2 | PAR);

    // Single frame 0x55.
    wb_write(8'h55, lat, acyc);
    check("write_latency", lat, 1);
    wb_read(st, lat);
    check("status_busy", st, 32'h6 | PAR);
    wait_frames(1);
    repeat (3) @(posedge clk);
    wb_read(st, lat);
    check("status_after_frame", st, 32'h2 | PAR);

    // Burst of six random bytes: the sixth stalls until the FSM pops the second.
    n0 = frame_starts.size();
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom());
      wb_write(b, lats[i], acycs[i]);
    end
    for (int i = 0; i < 5; i++) check("burst_write_latency", lats[i], 1);
    check("burst_write_stalled", {31'h0, (lats[5] > 1)}, 32'h1);
    if (frame_starts.size() > n0 + 1)
      check("stall_ack_after_pop", acycs[5] - frame_starts[n0+1], 1);
    else
      check("stall_ack_after_pop", frame_starts.size(), n0 + 2);
    wait_frames(frames_done + exp_q.size());
    for (int i = 1; i < 6; i++) begin
      if (frame_starts.size() > n0 + i)
        check("frame_spacing", frame_starts[n0+i] - frame_starts[n0+i-1], FRAME_LEN + 1);
      else
        check("frame_spacing_missing", frame_starts.size(), n0 + 6);
    end

    // Parity-sensitive bytes (bit count odd / even).
    wb_write(8'h07, lat, acyc);
    wb_write(8'h03, lat, acyc);
    wait_frames(frames_done + exp_q.size());

    // STB held across two sampling edges: one ACK, one push.
    wb_write(8'($urandom()), lat, acyc);
    @(posedge clk);
    #1;
    b          = 8'($urandom());
    exp_q.push_back(b);
    dat_w      = 32'h0;
    dat_w[7:0] = b;
    we = 1'b1; cyc = 1'b1; stb = 1'b1;
    nacks = 0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      if (ack) nacks++;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (ack) nacks++;
    end
    check("held_stb_ack_count", nacks, 1);
    wb_read(st, lat);
    check("held_stb_status", st, 32'h0000_0104 | PAR);
    wait_frames(frames_done + exp_q.size());

    // Reset in the middle of a frame with two bytes still queued.
    n0 = frame_starts.size();
    wb_write(8'h0F, lat, acyc);
    wb_write(8'($urandom()), lat, acyc);
    wb_write(8'($urandom()), lat, acyc);
    t = 0;
    while (frame_starts.size() == n0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    check("reset_frame_started", frame_starts.size(), n0 + 1);
    // Main thread is now at the start of frame cycle 1; advance into data bit 5 (a zero).
    repeat (24) @(posedge clk);
    #2;
    check("pre_reset_tx_low", {31'h0, tx}, 32'h0);
    rst_n = 1'b0;
    #1;
    check("async_reset_tx", {31'h0, tx}, 32'h1);
    check("async_reset_ack", {31'h0, ack}, 32'h0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    exp_q.delete();
    wb_read(st, lat);
    check("status_after_abort", st, 32'h2 | PAR);
    lows = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("no_frame_after_abort", lows, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
